// File: rtl/frame_blit_engine.sv
// Timer-driven frame copier: per tick, copies one FRAME_WORDS slot into VRAM at 3 cycles/word, 3*FRAME_WORDS+3 cycles per frame.
// No backpressure mid-copy; irq is sampled only in IDLE, and a tick arriving while gpuReady is low is dropped and counted.
module frame_blit_engine #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int FRAME_WORDS = 2048,
  parameter int NUM_FRAMES = 4,
  parameter logic [ADDR_W-1:0] SRC_BASE = '0,
  parameter logic [ADDR_W-1:0] DST_BASE = ADDR_W'(16'hA000),
  parameter int SKIP_W = 8,
  localparam int FI_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [1:0]        irq,
  output logic              iack,
  output logic              iend,
  input  logic [7:0]        kbd,
  input  logic              gpuReady,
  output logic              gpuDraw,
  output logic              memEnable,
  output logic              memWrite,
  output logic [ADDR_W-1:0] memAddr,
  input  logic [DATA_W-1:0] memDataR,
  output logic [DATA_W-1:0] memDataW,
  output logic [FI_W-1:0]   frameIdx,
  output logic              autoMode,
  output logic              busy,
  output logic [SKIP_W-1:0] skipCount
);

  localparam int OFF_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [OFF_W-1:0]  LAST_OFF = OFF_W'(FRAME_WORDS - 1);
  localparam logic [FI_W-1:0]   LAST_FI  = FI_W'(NUM_FRAMES - 1);
  localparam logic [ADDR_W-1:0] FW_A     = ADDR_W'(FRAME_WORDS);
  localparam logic [7:0]        KEY_LO   = 8'h31;
  localparam logic [7:0]        KEY_HI   = 8'(8'h30 + NUM_FRAMES);
  localparam logic [7:0]        KEY_AUTO = 8'h61;

  typedef enum logic [3:0] {
    S_IDLE, S_T_ACK, S_SKIP, S_RD, S_LATCH, S_WR, S_NEXT, S_DONE,
    S_K_ACK, S_K_LOAD, S_K_DEC
  } state_t;

  state_t            r_state;
  logic [OFF_W-1:0]  r_offset;
  logic [DATA_W-1:0] r_buf;
  logic [7:0]        r_kbuf;
  logic [FI_W-1:0]   r_frame;
  logic              r_auto;
  logic [SKIP_W-1:0] r_skip;

  logic [ADDR_W-1:0] w_src_addr;
  logic [ADDR_W-1:0] w_dst_addr;
  logic              w_key_slot;

  assign w_src_addr = SRC_BASE + ADDR_W'(r_frame) * FW_A + ADDR_W'(r_offset);
  assign w_dst_addr = DST_BASE + ADDR_W'(r_offset);
  assign w_key_slot = (r_kbuf >= KEY_LO) && (r_kbuf <= KEY_HI);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state  <= S_IDLE;
      r_offset <= '0;
      r_buf    <= '0;
      r_kbuf   <= '0;
      r_frame  <= '0;
      r_auto   <= 1'b0;
      r_skip   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (irq == 2'd0)      r_state <= S_T_ACK;
          else if (irq == 2'd1) r_state <= S_K_ACK;
        end
        S_T_ACK: begin
          if (gpuReady) begin
            r_offset <= '0;
            r_state  <= S_RD;
          end else begin
            r_state <= S_SKIP;
          end
        end
        S_SKIP: begin
          if (r_skip != '1) r_skip <= r_skip + 1'b1;
          r_state <= S_IDLE;
        end
        S_RD:    r_state <= S_LATCH;
        S_LATCH: begin
          r_buf   <= memDataR;
          r_state <= S_WR;
        end
        // WR advances the offset itself so each word costs 3 cycles; NEXT runs once per frame.
        S_WR: begin
          if (r_offset == LAST_OFF) begin
            r_state <= S_NEXT;
          end else begin
            r_offset <= r_offset + 1'b1;
            r_state  <= S_RD;
          end
        end
        S_NEXT: r_state <= S_DONE;
        S_DONE: begin
          if (r_auto) r_frame <= (r_frame == LAST_FI) ? '0 : r_frame + 1'b1;
          r_state <= S_IDLE;
        end
        S_K_ACK:  r_state <= S_K_LOAD;
        S_K_LOAD: begin
          r_kbuf  <= kbd;
          r_state <= S_K_DEC;
        end
        S_K_DEC: begin
          if (w_key_slot)                r_frame <= FI_W'(r_kbuf - KEY_LO);
          else if (r_kbuf == KEY_AUTO)   r_auto  <= ~r_auto;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign iack      = (r_state == S_T_ACK) || (r_state == S_K_ACK);
  assign iend      = (r_state == S_SKIP) || (r_state == S_DONE) || (r_state == S_K_DEC);
  assign gpuDraw   = (r_state == S_DONE);
  assign memEnable = (r_state == S_RD) || (r_state == S_WR);
  assign memWrite  = (r_state == S_WR);
  assign memAddr   = (r_state == S_RD) ? w_src_addr :
                     (r_state == S_WR) ? w_dst_addr : '0;
  assign memDataW  = r_buf;
  assign frameIdx  = r_frame;
  assign autoMode  = r_auto;
  assign busy      = (r_state != S_IDLE);
  assign skipCount = r_skip;

endmodule
